// File: rtl/weekday_pkg.sv
// Shared constants for the weekday display controller: day codes, letter
// widths and segment encodings (segment a is the MSB of each letter).
package weekday_pkg;

    localparam logic [2:0] SUN = 3'd0;
    localparam logic [2:0] MON = 3'd1;
    localparam logic [2:0] TUE = 3'd2;
    localparam logic [2:0] WED = 3'd3;
    localparam logic [2:0] THU = 3'd4;
    localparam logic [2:0] FRI = 3'd5;
    localparam logic [2:0] SAT = 3'd6;
    localparam int         DAYS = 7;

    localparam int L0_W = 20;
    localparam int LN_W = 10;

    // Wide first-letter glyphs
    localparam logic [L0_W-1:0] LTR_S = 20'b11001000010000010111;
    localparam logic [L0_W-1:0] LTR_M = 20'b00101000000110110000;
    localparam logic [L0_W-1:0] LTR_T = 20'b11000001000001000000;
    localparam logic [L0_W-1:0] LTR_W = 20'b00010110110000001000;
    localparam logic [L0_W-1:0] LTR_F = 20'b11000000000100010110;

    // Narrow second/third-letter glyphs
    localparam logic [LN_W-1:0] LTR_U  = 10'b1111100000;
    localparam logic [LN_W-1:0] LTR_N  = 10'b1001110101;
    localparam logic [LN_W-1:0] LTR_H  = 10'b1110100001;
    localparam logic [LN_W-1:0] LTR_A  = 10'b0000011111;
    localparam logic [LN_W-1:0] LTR_TN = 10'b0110001010;

    function automatic logic [2:0] next_day(input logic [2:0] day);
        return (day == SAT) ? SUN : day + 3'd1;
    endfunction

endpackage

// File: rtl/weekday_letter_rom.sv
// Combinational day code -> three-letter segment patterns; code 7 is blank.
module weekday_letter_rom
    import weekday_pkg::*;
(
    input  logic [2:0]      day,
    output logic [L0_W-1:0] l0,
    output logic [LN_W-1:0] l1,
    output logic [LN_W-1:0] l2
);

    always_comb begin
        l0 = '0;
        l1 = '0;
        l2 = '0;
        case (day)
            SUN: begin l0 = LTR_S; l1 = LTR_U; l2 = LTR_N;  end
            MON: l0 = LTR_M;
            TUE: l0 = LTR_T;
            WED: l0 = LTR_W;
            THU: begin l0 = LTR_T; l1 = LTR_H; end
            FRI: l0 = LTR_F;
            SAT: begin l0 = LTR_S; l1 = LTR_A; l2 = LTR_TN; end
            default: ;
        endcase
    end

endmodule

// File: rtl/weekday_display_ctrl.sv
// Weekday register with midnight advance, button editing and registered
// segment outputs. Define WEEKDAY_BLINK_EN to blink the display while editing.
module weekday_display_ctrl
    import weekday_pkg::*;
#(
    parameter int START_DAY = 0,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              day_tick,
    input  logic              set_en,
    input  logic              set_inc,
    output logic [2:0]        weekday,
    output logic              week_wrap,
    output logic [L0_W-1:0]   disp_l0,
    output logic [LN_W-1:0]   disp_l1,
    output logic [LN_W-1:0]   disp_l2
);

    localparam logic [2:0] RST_DAY = 3'(START_DAY);

    logic [2:0]      weekday_q, weekday_d;
    logic            week_wrap_q, week_wrap_d;
    logic            set_inc_q, set_inc_d;
    logic [L0_W-1:0] disp_l0_q, disp_l0_d;
    logic [LN_W-1:0] disp_l1_q, disp_l1_d;
    logic [LN_W-1:0] disp_l2_q, disp_l2_d;
    logic            adv_tick, adv_set;
    logic            blank;
    logic [L0_W-1:0] rom_l0;
    logic [LN_W-1:0] rom_l1, rom_l2;

    // set_en selects exactly one advance source, so a double step cannot occur
    always_comb begin
        set_inc_d   = set_inc;
        adv_tick    = day_tick & ~set_en;
        adv_set     = set_inc & ~set_inc_q & set_en;
        weekday_d   = weekday_q;
        week_wrap_d = 1'b0;
        if (adv_tick || adv_set) weekday_d = next_day(weekday_q);
        if (adv_tick && (weekday_q == SAT)) week_wrap_d = 1'b1;
    end

`ifdef WEEKDAY_BLINK_EN
    localparam int              CNT_W    = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             set_en_q, set_en_d;

    // Blank decision uses next phase so each window is exactly BLINK_DIV outputs
    always_comb begin
        set_en_d = set_en;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (!set_en || !set_en_q) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        blank = set_en & ~phase_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            set_en_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            set_en_q <= set_en_d;
        end
    end
`else
    assign blank = 1'b0;
`endif

    weekday_letter_rom u_rom (
        .day (weekday_q),
        .l0  (rom_l0),
        .l1  (rom_l1),
        .l2  (rom_l2)
    );

    always_comb begin
        disp_l0_d = blank ? '0 : rom_l0;
        disp_l1_d = blank ? '0 : rom_l1;
        disp_l2_d = blank ? '0 : rom_l2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            weekday_q   <= RST_DAY;
            week_wrap_q <= 1'b0;
            set_inc_q   <= 1'b0;
            disp_l0_q   <= '0;
            disp_l1_q   <= '0;
            disp_l2_q   <= '0;
        end else begin
            weekday_q   <= weekday_d;
            week_wrap_q <= week_wrap_d;
            set_inc_q   <= set_inc_d;
            disp_l0_q   <= disp_l0_d;
            disp_l1_q   <= disp_l1_d;
            disp_l2_q   <= disp_l2_d;
        end
    end

    assign weekday   = weekday_q;
    assign week_wrap = week_wrap_q;
    assign disp_l0   = disp_l0_q;
    assign disp_l1   = disp_l1_q;
    assign disp_l2   = disp_l2_q;

endmodule

// File: tb/tb_weekday_display_ctrl.sv
// Bench for weekday_display_ctrl: vector table with a scoreboard queue plus
// hand sequences for reset, held button, blink windows and reset mid-edit.
module tb_weekday_display_ctrl;

`ifdef WEEKDAY_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [19:0] E_S  = 20'b11001000010000010111;
    localparam logic [19:0] E_M  = 20'b00101000000110110000;
    localparam logic [19:0] E_F  = 20'b11000000000100010110;
    localparam logic [9:0]  E_U  = 10'b1111100000;
    localparam logic [9:0]  E_N  = 10'b1001110101;
    localparam logic [9:0]  E_A  = 10'b0000011111;
    localparam logic [9:0]  E_TN = 10'b0110001010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic day_tick = 1'b0, set_en = 1'b0, set_inc = 1'b0;
    logic tick5 = 1'b0;
    logic [2:0]  weekday, weekday5;
    logic        week_wrap, week_wrap5;
    logic [19:0] disp_l0, disp5_l0;
    logic [9:0]  disp_l1, disp_l2, disp5_l1, disp5_l2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    weekday_display_ctrl #(.START_DAY(0), .BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .day_tick(day_tick), .set_en(set_en),
        .set_inc(set_inc), .weekday(weekday), .week_wrap(week_wrap),
        .disp_l0(disp_l0), .disp_l1(disp_l1), .disp_l2(disp_l2)
    );

    weekday_display_ctrl #(.START_DAY(5), .BLINK_DIV(4)) dut5 (
        .clk(clk), .reset(reset), .day_tick(tick5), .set_en(1'b0),
        .set_inc(1'b0), .weekday(weekday5), .week_wrap(week_wrap5),
        .disp_l0(disp5_l0), .disp_l1(disp5_l1), .disp_l2(disp5_l2)
    );

    typedef struct {
        bit         tick;
        bit         sen;
        bit         inc;
        logic [2:0] day;
        bit         wrap;
    } vec_t;

    typedef struct {
        logic [2:0] day;
        bit         wrap;
    } sb_t;

    vec_t vecs[22];
    sb_t  sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        sb_t         e;
        logic [19:0] exp_l0;
        logic [9:0]  exp_l1;

        vecs[0]  = '{1, 0, 0, 3'd1, 0};
        vecs[1]  = '{0, 0, 0, 3'd1, 0};
        vecs[2]  = '{1, 0, 0, 3'd2, 0};
        vecs[3]  = '{0, 1, 1, 3'd3, 0};
        vecs[4]  = '{0, 1, 1, 3'd3, 0};
        vecs[5]  = '{1, 1, 1, 3'd3, 0};
        vecs[6]  = '{0, 1, 0, 3'd3, 0};
        vecs[7]  = '{1, 1, 1, 3'd4, 0};
        vecs[8]  = '{0, 1, 0, 3'd4, 0};
        vecs[9]  = '{0, 0, 1, 3'd4, 0};
        vecs[10] = '{1, 0, 0, 3'd5, 0};
        vecs[11] = '{1, 0, 0, 3'd6, 0};
        vecs[12] = '{0, 1, 0, 3'd6, 0};
        vecs[13] = '{0, 1, 1, 3'd0, 0};
        vecs[14] = '{1, 0, 0, 3'd1, 0};
        vecs[15] = '{1, 0, 0, 3'd2, 0};
        vecs[16] = '{1, 0, 0, 3'd3, 0};
        vecs[17] = '{1, 0, 0, 3'd4, 0};
        vecs[18] = '{1, 0, 0, 3'd5, 0};
        vecs[19] = '{1, 0, 0, 3'd6, 0};
        vecs[20] = '{1, 0, 0, 3'd0, 1};
        vecs[21] = '{0, 0, 0, 3'd0, 0};

        // Reset state and first edge after release
        tick_clk();
        check("rst_l0", disp_l0, 0);
        check("rst_l1", disp_l1, 0);
        check("rst_l2", disp_l2, 0);
        check("rst_day", weekday, 0);
        check("rst_wrap", week_wrap, 0);
        reset = 1'b0;
        tick_clk();
        check("rel_day", weekday, 0);
        check("rel_l0", disp_l0, E_S);
        check("rel_l1", disp_l1, E_U);
        check("rel_l2", disp_l2, E_N);
        check("rel5_day", weekday5, 5);
        check("rel5_l0", disp5_l0, E_F);

        // START_DAY=5, two ticks through the week wrap
        tick5 = 1'b1;
        tick_clk();
        check("t5_day6", weekday5, 6);
        check("t5_wrap_a", week_wrap5, 0);
        tick_clk();
        check("t5_day0", weekday5, 0);
        check("t5_wrap_b", week_wrap5, 1);
        check("t5_sat_l0", disp5_l0, E_S);
        check("t5_sat_l1", disp5_l1, E_A);
        check("t5_sat_l2", disp5_l2, E_TN);
        tick5 = 1'b0;
        tick_clk();
        check("t5_wrap_c", week_wrap5, 0);
        check("t5_sun_l2", disp5_l2, E_N);

        // Table vectors through the scoreboard
        for (int i = 0; i < 22; i++) begin
            day_tick = vecs[i].tick;
            set_en   = vecs[i].sen;
            set_inc  = vecs[i].inc;
            sb_q.push_back('{vecs[i].day, vecs[i].wrap});
            tick_clk();
            e = sb_q.pop_front();
            check($sformatf("vec%0d_day", i), weekday, e.day);
            check($sformatf("vec%0d_wrap", i), week_wrap, e.wrap);
        end
        day_tick = 1'b0;
        set_en   = 1'b0;
        set_inc  = 1'b0;

        // Held button gives one advance
        do_reset();
        set_en  = 1'b1;
        set_inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            if (i == 0 || i == 9) check($sformatf("hold%0d_day", i), weekday, 1);
        end
        set_en  = 1'b0;
        set_inc = 1'b0;
        tick_clk();
        check("hold_day", weekday, 1);
        check("hold_l0", disp_l0, E_M);
        check("hold_l1", disp_l1, 0);
        check("hold_l2", disp_l2, 0);

        // Blink windows in edit mode
        do_reset();
        set_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick_clk();
            exp_l0 = (BLINK_ON && (i % 8) >= 4) ? 20'd0 : E_S;
            exp_l1 = (BLINK_ON && (i % 8) >= 4) ? 10'd0 : E_U;
            check($sformatf("blink%0d_l0", i), disp_l0, exp_l0);
            check($sformatf("blink%0d_l1", i), disp_l1, exp_l1);
        end
        set_inc = 1'b1;
        tick_clk();
        set_inc = 1'b0;
        repeat (4) tick_clk();
        check("blank_day", weekday, 1);
        check("blank_l0", disp_l0, BLINK_ON ? 20'd0 : E_M);

        // Reset mid-blank with set_en still high
        reset = 1'b1;
        tick_clk();
        check("mid_rst_day", weekday, 0);
        check("mid_rst_l0", disp_l0, 0);
        tick_clk();
        reset = 1'b0;
        tick_clk();
        check("post_rst_day", weekday, 0);
        check("post_rst_l0", disp_l0, E_S);
        check("post_rst_l1", disp_l1, E_U);
        tick_clk();
        check("post_rst_l0b", disp_l0, E_S);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/weekday_display_ctrl.md
# weekday_display_ctrl

Sequential successor to the combinational weekday letter decoder. It holds the current weekday, advances it on the clock core's midnight pulse and supports user editing with a button. While editing it blinks the display. It drives registered segment patterns for a three-letter weekday field: one 20-segment letter followed by two 10-segment letters. It sits between the time-of-day counter and the LED segment drivers.

## Interface
- START_DAY, 0, weekday loaded at reset (0..6; SUN=0, M=1, T=2, W=3, TH=4, F=5, SAT=6)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥2)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- day_tick  in  1  one-cycle pulse at midnight rollover
- set_en  in  1  level; edit mode while high
- set_inc  in  1  raw button level (already debounced); rising edge advances day in edit mode
- weekday  out  3  current day, 0..6
- week_wrap  out  1  one-cycle pulse when day_tick wraps SAT→SUN
- disp_l0  out  20  first letter, bit 19 = segment a … bit 0 = segment t
- disp_l1  out  10  second letter, bit 9 = segment a … bit 0 = segment j
- disp_l2  out  10  third letter, same ordering as disp_l1

## Operation
- Reset:
  - weekday=START_DAY; week_wrap=0.
  - disp_l0/l1/l2=0.
  - Edge-detect register=0; blink counter=0; blink phase=1 (visible).
- Day register:
  - Next value is (weekday+1) mod 7 on an accepted advance.
  - A day_tick advance is accepted only when set_en=0.
  - A set_inc rising edge advances only when set_en=1. An edge while set_en=0 is dropped.
  - set_inc edge detection: rise = set_inc & ~set_inc_q; set_inc_q is registered every cycle. Holding the button gives exactly one advance.
  - week_wrap=1 only for a day_tick advance from 6 to 0. A set_inc wrap from 6 to 0 does not pulse week_wrap.
  - If day_tick and a set_inc edge occur in the same cycle, exactly one is relevant given set_en. No double step is possible.
- Letter encodings (first letter, 20 bits a..t):
  - S=11001000010000010111
  - M=00101000000110110000
  - T=11000001000001000000
  - W=00010110110000001000
  - F=11000000000100010110
- Day → letters:
  - day 0 → S / U=1111100000 / N=1001110101
  - day 1 → M/0/0
  - day 2 → T/0/0
  - day 3 → W/0/0
  - day 4 → T / H=1110100001 / 0
  - day 5 → F/0/0
  - day 6 → S / A=0000011111 / T=0110001010
  - Unused letter positions are 0.
- Blink:
  - Blanking applies only while set_en=1.
  - The counter runs 0..BLINK_DIV-1. At the terminal count it returns to 0 and the phase toggles.
  - On a set_en rising edge, or whenever set_en=0, the counter clears to 0 and phase is set to 1.
  - While set_en=1 and phase=0, all three disp outputs are 0.

## Timing
- weekday and week_wrap update on the edge after the accepted event: 1-cycle latency from day_tick or the set_inc rise.
- disp_* are registered from the current weekday and blank state: 1 further cycle, so 2 cycles from the event.
- After reset release, disp_* show START_DAY on the first edge.
- In edit mode the display is visible for BLINK_DIV cycles, then blank for BLINK_DIV cycles, repeating. The first visible window starts on the edge at which set_en is first sampled high.
- Reset mid-edit returns every register to its reset value. No partial advance survives.

## Configuration
- WEEKDAY_BLINK_EN defined:
  - Blink counter and phase logic present.
  - Blanking in edit mode as described.
- WEEKDAY_BLINK_EN undefined:
  - No counter.
  - Display is never blanked.
  - Edit mode only gates the advance sources.
  - BLINK_DIV is ignored.

## Structure
- Package weekday_pkg holds:
  - Day constants SUN..SAT and DAYS=7.
  - Letter widths L0_W=20 and LN_W=10.
  - All letter encodings above.
- Sub-module weekday_letter_rom: combinational day[2:0] → {l0,l1,l2}. Out-of-range codes 7 give all zeros.
- The top level holds the day register, edge detect, blink counter and output registers.

## Test plan
- Reset, START_DAY=0 → disp all 0 during reset; on the first edge after release: weekday=0, disp_l0=11001000010000010111, disp_l1=1111100000, disp_l2=1001110101.
- START_DAY=5, 2 day_ticks → weekday 6 then 0. week_wrap is high only on the 6→0 cycle. disp_l2=0110001010 while day=6.
- set_en=1, set_inc held high 10 cycles from day 0 → single advance to 1; disp_l0=00101000000110110000, disp_l1=disp_l2=0.
- set_en=1 with day_tick pulsed → no change. set_en=0 with a set_inc rise → no change. set_inc from day 6 → 0 with week_wrap=0.
- BLINK_DIV=4, macro defined, set_en=1 → disp visible 4 cycles, blank 4 cycles, repeating. Macro undefined → never blank.
- Reset asserted mid-blank in edit mode → weekday=START_DAY; after release, disp is visible immediately even with set_en still high.
